fp_addsub_norm_ctrl: RTL and testbench
======================================

// Module: fp_addsub_norm_ctrl
// PURPOSE
//  Sequencer for post-add/sub normalization in the FP add/sub path.
//  Accepts a raw significand (plus carry) and exponent from the adder stage, runs leading-zero detection, and applies one right or left normalizing shift with exponent correction.
//  Multi-cycle FSM with valid/ready on both sides; sits between the significand adder and the rounding stage.
// PARAMETERS
//  SW  55  significand width excl. carry bit (double: 52 frac + hidden + 2 guard)
//  EW  11  exponent width
//  CW  6   shift-count width, ceil(log2(SW+1))
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous active-high reset
//  in_valid_i   in   1   input operand valid
//  in_ready_o   out  1   block can accept an operand (IDLE only)
//  carry_i      in   1   adder carry-out (bit SW of raw sum)
//  sig_i        in   SW  raw significand, MSB = hidden-bit position
//  exp_i        in   EW  unbiased-as-stored exponent of the sum
//  out_valid_o  out  1   result valid (DONE only)
//  out_ready_i  in   1   downstream accepts result
//  sig_o        out  SW  normalized significand
//  exp_o        out  EW  corrected exponent
//  shift_o      out  CW  left-shift amount applied (0 on right-shift/zero path)
//  zero_o       out  1   sum was exactly zero
//  underflow_o  out  1   left shift clamped by exponent, result denormal
//  overflow_o   out  1   exponent reached all-ones on right shift
// BEHAVIOUR
//  Reset: state=IDLE; in_ready_o=1; out_valid_o=0; sig_o, exp_o, shift_o=0; zero_o, underflow_o, overflow_o=0.
//  States: IDLE -> DETECT -> {SHIFT_R | SHIFT_L | DONE} -> DONE -> IDLE.
//  IDLE: in_ready_o=1; on in_valid_i & in_ready_o, capture carry/sig/exp, go to DETECT.
//  DETECT: lz = leading-zero count of captured sig (0..SW; SW means all zero).
//    carry=1 -> SHIFT_R. carry=0 & lz==SW -> sig_o=0, exp_o=0, zero_o=1, go DONE.
//    Otherwise register lz, go SHIFT_L.
//  SHIFT_R: sig_o = {1'b1, sig[SW-1:2], sig[1]|sig[0]} (bit0 sticky); exp_o = exp+1.
//    If exp+1 == 2^EW-1: overflow_o=1, exp_o=all ones, sig_o=0. Then go DONE.
//  SHIFT_L: if lz < exp: sig_o = sig<<lz, exp_o = exp-lz, shift_o = lz.
//    Else: sig_o = sig<<exp, exp_o=0, shift_o=exp[CW-1:0], underflow_o=1 (exp=0 -> no shift). Then go DONE.
//  DONE: out_valid_o=1; all outputs held stable until out_ready_i=1, then go IDLE (flags cleared on exit).
//  Latency: accept on edge k -> out_valid_o high from cycle k+3 (zero path k+2).
//  Throughput: at most one operand per 4 cycles; no accept in the same cycle as out handshake.
//  rst mid-operation: in-flight operand dropped, reset values apply next cycle.
//  Flags mutually exclusive; out_valid_o never asserts without a prior accept.
//  Exponent arithmetic: exp-lz done in EW+1 bits, with no wrap.
// STRUCTURE
//  Package fp_addsub_pkg: state encoding localparams, SW/EW/CW defaults, EXP_MAX constant.
//  Sub-module norm_lzd: combinational LZD, SW in -> CW out, count of leading zeros, SW when input=0.
//    Shared with the multiplier normalization path.
//  Left shifter: single-cycle barrel shifter inside this module; registered output.
// TESTING
//  1 sig=1<<54, carry=0, exp=100 -> sig_o=1<<54, exp_o=100, shift_o=0, valid at k+3.
//  2 sig=55'h1, exp=1000 -> sig_o=1<<54, exp_o=946, shift_o=54, no flags.
//  3 sig=0, carry=0, exp=500 -> zero_o=1, sig_o=0, exp_o=0, valid at k+2.
//  4 carry=1, sig=55'h3, exp=10 -> sig_o={1,53'h0,1}, exp_o=11; carry=1, exp=2046 -> overflow_o=1, exp_o=2047.
//  5 sig=1<<44 (lz=10), exp=4 -> sig_o=1<<48, exp_o=0, shift_o=4, underflow_o=1.
//  6 out_ready_i low 5 cycles -> outputs stable, in_ready_o=0; rst in SHIFT_L -> IDLE, out_valid_o never pulses.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// Shared constants and FSM encoding for the FP add/sub normalization sequencer.
// Defaults describe the double-precision datapath.
package fp_addsub_pkg;

   localparam int unsigned SW_DEF = 55;
   localparam int unsigned EW_DEF = 11;
   localparam int unsigned CW_DEF = 6;

   localparam logic [EW_DEF-1:0] EXP_MAX = '1;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StDetect = 3'd1,
      StShiftR = 3'd2,
      StShiftL = 3'd3,
      StDone   = 3'd4
   } state_e;

endpackage

// File: rtl/norm_lzd.sv
// Combinational leading-zero detector; returns SW for an all-zero input.
// Shared between the add/sub and multiplier normalization paths.
module norm_lzd #(
   parameter int unsigned SW = 55,
   parameter int unsigned CW = 6
) (
   input  logic [SW-1:0] sig_i,
   output logic [CW-1:0] lz_o
);

   // Ascending scan: the highest set bit is the last one to write the count.
   always_comb begin
      lz_o = CW'(SW);
      for (int unsigned i = 0; i < SW; i++) begin
         if (sig_i[i]) begin
            lz_o = CW'(SW - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_addsub_norm_ctrl.sv
// Post-add/sub normalization sequencer: one right shift on carry-out, otherwise one
// LZD-driven left shift clamped by the exponent, with registered outputs and valid/ready.
module fp_addsub_norm_ctrl
   import fp_addsub_pkg::*;
#(
   parameter int unsigned SW = SW_DEF,
   parameter int unsigned EW = EW_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic          carry_i,
   input  logic [SW-1:0] sig_i,
   input  logic [EW-1:0] exp_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [SW-1:0] sig_o,
   output logic [EW-1:0] exp_o,
   output logic [CW-1:0] shift_o,
   output logic          zero_o,
   output logic          underflow_o,
   output logic          overflow_o
);

   localparam logic [EW:0] ExpMaxExt = {1'b0, {EW{1'b1}}};

   state_e        state_q, state_d;
   logic          carry_q, carry_d;
   logic [SW-1:0] sig_q, sig_d;
   logic [EW-1:0] exp_q, exp_d;
   logic [CW-1:0] lz_q, lz_d;
   logic [SW-1:0] rsig_q, rsig_d;
   logic [EW-1:0] rexp_q, rexp_d;
   logic [CW-1:0] rshift_q, rshift_d;
   logic          zero_q, zero_d;
   logic          uf_q, uf_d;
   logic          of_q, of_d;

   logic [CW-1:0] lz;
   logic [EW-1:0] lz_ext;
   logic [EW:0]   exp_inc;
   logic          lz_lt_exp;
   logic [CW-1:0] shamt;

   norm_lzd #(
      .SW (SW),
      .CW (CW)
   ) u_lzd (
      .sig_i (sig_q),
      .lz_o  (lz)
   );

   assign lz_ext    = {{(EW-CW){1'b0}}, lz_q};
   assign exp_inc   = {1'b0, exp_q} + {{EW{1'b0}}, 1'b1};
   assign lz_lt_exp = lz_ext < exp_q;
   // When clamped, exp_q <= lz_q, so its low CW bits carry the whole value.
   assign shamt     = lz_lt_exp ? lz_q : exp_q[CW-1:0];

   always_comb begin
      state_d  = state_q;
      carry_d  = carry_q;
      sig_d    = sig_q;
      exp_d    = exp_q;
      lz_d     = lz_q;
      rsig_d   = rsig_q;
      rexp_d   = rexp_q;
      rshift_d = rshift_q;
      zero_d   = zero_q;
      uf_d     = uf_q;
      of_d     = of_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               carry_d = carry_i;
               sig_d   = sig_i;
               exp_d   = exp_i;
               state_d = StDetect;
            end
         end
         StDetect: begin
            if (carry_q) begin
               state_d = StShiftR;
            end else if (lz == CW'(SW)) begin
               rsig_d   = '0;
               rexp_d   = '0;
               rshift_d = '0;
               zero_d   = 1'b1;
               uf_d     = 1'b0;
               of_d     = 1'b0;
               state_d  = StDone;
            end else begin
               lz_d    = lz;
               state_d = StShiftL;
            end
         end
         StShiftR: begin
            rshift_d = '0;
            zero_d   = 1'b0;
            uf_d     = 1'b0;
            if (exp_inc >= ExpMaxExt) begin
               rsig_d = '0;
               rexp_d = '1;
               of_d   = 1'b1;
            end else begin
               // Sticky bit keeps the inexact information lost from the two LSBs.
               rsig_d = {1'b1, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
               rexp_d = exp_inc[EW-1:0];
               of_d   = 1'b0;
            end
            state_d = StDone;
         end
         StShiftL: begin
            rsig_d   = sig_q << shamt;
            rshift_d = shamt;
            zero_d   = 1'b0;
            of_d     = 1'b0;
            uf_d     = ~lz_lt_exp;
            rexp_d   = lz_lt_exp ? (exp_q - lz_ext) : '0;
            state_d  = StDone;
         end
         StDone: begin
            if (out_ready_i) begin
               zero_d  = 1'b0;
               uf_d    = 1'b0;
               of_d    = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         carry_q  <= 1'b0;
         sig_q    <= '0;
         exp_q    <= '0;
         lz_q     <= '0;
         rsig_q   <= '0;
         rexp_q   <= '0;
         rshift_q <= '0;
         zero_q   <= 1'b0;
         uf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         carry_q  <= carry_d;
         sig_q    <= sig_d;
         exp_q    <= exp_d;
         lz_q     <= lz_d;
         rsig_q   <= rsig_d;
         rexp_q   <= rexp_d;
         rshift_q <= rshift_d;
         zero_q   <= zero_d;
         uf_q     <= uf_d;
         of_q     <= of_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign sig_o       = rsig_q;
   assign exp_o       = rexp_q;
   assign shift_o     = rshift_q;
   assign zero_o      = zero_q;
   assign underflow_o = uf_q;
   assign overflow_o  = of_q;

endmodule

// File: tb/tb_fp_addsub_norm_ctrl.sv
// Bench for fp_addsub_norm_ctrl: directed corner cases plus random operands checked
// against an arithmetic reference model of the normalization rules.
module tb_fp_addsub_norm_ctrl;

   localparam int SW = 55;
   localparam int EW = 11;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid_i, in_ready_o, carry_i;
   logic [SW-1:0] sig_i;
   logic [EW-1:0] exp_i;
   logic          out_valid_o, out_ready_i;
   logic [SW-1:0] sig_o;
   logic [EW-1:0] exp_o;
   logic [CW-1:0] shift_o;
   logic          zero_o, underflow_o, overflow_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      longint unsigned sig;
      int unsigned     expo;
      int unsigned     shift;
      bit              zero, uf, of;
      int              lat;
   } res_t;

   fp_addsub_norm_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .carry_i     (carry_i),
      .sig_i       (sig_i),
      .exp_i       (exp_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .sig_o       (sig_o),
      .exp_o       (exp_o),
      .shift_o     (shift_o),
      .zero_o      (zero_o),
      .underflow_o (underflow_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: normalization expressed as plain integer arithmetic.
   function automatic res_t model(input bit c, input longint unsigned s, input int unsigned e);
      res_t            r;
      longint unsigned mask = (64'd1 << SW) - 1;
      longint unsigned v;
      int              msb, lz;
      r = '{sig: 0, expo: 0, shift: 0, zero: 0, uf: 0, of: 0, lat: 2};
      s = s & mask;
      if (c) begin
         if (e + 1 == 2047) begin
            r.of = 1; r.expo = 2047; r.sig = 0;
         end else begin
            r.expo = e + 1;
            r.sig  = (64'd1 << (SW - 1)) | ((s / 4) * 2) | ((s % 4) != 0 ? 64'd1 : 64'd0);
         end
      end else if (s == 0) begin
         r.zero = 1; r.lat = 1;
      end else begin
         msb = -1; v = s;
         while (v > 0) begin v = v / 2; msb++; end
         lz = SW - 1 - msb;
         if (lz < int'(e)) begin
            r.sig = (s * (64'd1 << lz)) & mask; r.expo = e - lz; r.shift = lz;
         end else begin
            r.sig = (s * (64'd1 << e)) & mask; r.expo = 0; r.shift = e; r.uf = 1;
         end
      end
      return r;
   endfunction

   task automatic run_op(input string tag, input bit c, input longint unsigned s,
                         input int unsigned e, input int hold);
      res_t r;
      int   n;
      r = model(c, s, e);
      @(negedge clk);
      check({tag, ".in_ready"}, 64'(in_ready_o), 64'd1);
      in_valid_i = 1'b1; carry_i = c; sig_i = s[SW-1:0]; exp_i = e[EW-1:0];
      @(negedge clk);
      in_valid_i = 1'b0;
      n = 0;
      while (!out_valid_o && n < 8) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".latency"}, 64'(n), 64'(r.lat));
      check({tag, ".sig"}, 64'(sig_o), r.sig);
      check({tag, ".exp"}, 64'(exp_o), 64'(r.expo));
      check({tag, ".shift"}, 64'(shift_o), 64'(r.shift));
      check({tag, ".flags"}, 64'({zero_o, underflow_o, overflow_o}), 64'({r.zero, r.uf, r.of}));
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({tag, ".hold_valid"}, 64'({out_valid_o, in_ready_o}), 64'b10);
         check({tag, ".hold_sig"}, 64'(sig_o), r.sig);
         check({tag, ".hold_exp"}, 64'(exp_o), 64'(r.expo));
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      check({tag, ".exit"}, 64'({out_valid_o, in_ready_o, zero_o, underflow_o, overflow_o}),
            64'b01000);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; in_valid_i = 1'b0; carry_i = 1'b0; sig_i = '0; exp_i = '0; out_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.hs", 64'({in_ready_o, out_valid_o}), 64'b10);
      check("reset.data", 64'({sig_o, exp_o, shift_o}), 64'd0);
      check("reset.flags", 64'({zero_o, underflow_o, overflow_o}), 64'd0);
      rst = 1'b0;

      run_op("t1_norm", 1'b0, 64'd1 << 54, 100, 0);
      run_op("t2_lz54", 1'b0, 64'd1, 1000, 1);
      run_op("t3_zero", 1'b0, 64'd0, 500, 0);
      run_op("t4_carry", 1'b1, 64'd3, 10, 0);
      run_op("t4_ovf", 1'b1, 64'h12_3456_789A_BCDE, 2046, 0);
      run_op("t5_uflow", 1'b0, 64'd1 << 44, 4, 0);
      run_op("t5_exp0", 1'b0, 64'd1 << 40, 0, 0);
      run_op("t6_stall", 1'b0, 64'h0F0F_0000_1234, 300, 5);

      // Reset while the left shift is pending must drop the operand silently.
      @(negedge clk);
      in_valid_i = 1'b1; carry_i = 1'b0; sig_i = 55'h1; exp_i = 11'd1000;
      @(negedge clk);
      in_valid_i = 1'b0;
      @(negedge clk);
      check("rst_mid.busy", 64'({in_ready_o, out_valid_o}), 64'b00);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid.idle", 64'({in_ready_o, out_valid_o}), 64'b10);
      check("rst_mid.data", 64'({sig_o, exp_o, shift_o}), 64'd0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen |= out_valid_o;
      end
      check("rst_mid.no_valid", 64'(seen), 64'd0);

      for (int i = 0; i < 40; i++) begin
         bit              c;
         longint unsigned s;
         int unsigned     e;
         c = ($urandom_range(0, 3) == 0);
         s = {$urandom, $urandom};
         s = s >> (9 + $urandom_range(0, 56));
         e = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 2046);
         run_op($sformatf("rnd%0d", i), c, s, e, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
